// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: sequencer state encoding and command/width codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lsu_pkg;

    // Byte sequencer states: idle, low-byte bus cycle, high-byte bus cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } lsu_state_t;

    localparam logic CMD_LOAD  = 1'b0;
    localparam logic CMD_STORE = 1'b1;

    localparam logic WIDTH_8   = 1'b0;
    localparam logic WIDTH_16  = 1'b1;

endpackage : lsu_pkg

// File: rtl/load_store_unit.sv
// Load/store unit: splits 8/16-bit requests into byte bus cycles, returns load data with its tag.
// Latency: with no wait states, 8-bit load writes back 2 cycles after accept and 16-bit 3 cycles.
// Backpressure: lsu_wait is high while a request is in progress (LO/HI), and new requests are ignored then.
// Optional macro LSU_WAIT_STATES_EN adds mem_ready, which stretches a bus cycle while it is low.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              a_rst,
    input  logic              rq_start,
    input  logic              rq_cmd,
    input  logic              rq_width,
    input  logic              rq_tag,
    input  logic [ADDR_W-1:0] rq_addr,
    input  logic [15:0]       rq_data,
`ifdef LSU_WAIT_STATES_EN
    input  logic              mem_ready,
`endif
    output logic              lsu_wait,
    output logic [15:0]       data_out,
    output logic              data_tag,
    output logic              data_wb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              mem_rd,
    output logic              mem_wr
);

    lsu_state_t        state, state_d;

    // Captured request fields; address and low store byte live in mem_addr/mem_wdata.
    logic              cmd_q,     cmd_d;
    logic              width_q,   width_d;
    logic              tag_q,     tag_d;
    logic [7:0]        data_hi_q, data_hi_d;
    logic [7:0]        lo_q,      lo_d;

    logic [15:0]       data_out_d;
    logic              data_tag_d;
    logic              data_wb_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [7:0]        mem_wdata_d;
    logic              mem_rd_d;
    logic              mem_wr_d;

    logic              bus_done;

`ifdef LSU_WAIT_STATES_EN
    assign bus_done = mem_ready;
`else
    assign bus_done = 1'b1;
`endif

    // Busy exactly while a request occupies the sequencer; state is a flop so this is registered.
    assign lsu_wait = (state != IDLE);

    // Register all state and outputs; reset aborts any access in flight.
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state     <= IDLE;
            cmd_q     <= CMD_LOAD;
            width_q   <= WIDTH_8;
            tag_q     <= 1'b0;
            data_hi_q <= 8'h00;
            lo_q      <= 8'h00;
            data_out  <= 16'h0000;
            data_tag  <= 1'b0;
            data_wb   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
        end else begin
            state     <= state_d;
            cmd_q     <= cmd_d;
            width_q   <= width_d;
            tag_q     <= tag_d;
            data_hi_q <= data_hi_d;
            lo_q      <= lo_d;
            data_out  <= data_out_d;
            data_tag  <= data_tag_d;
            data_wb   <= data_wb_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_rd    <= mem_rd_d;
            mem_wr    <= mem_wr_d;
        end
    end

    // Next-state and next-output logic; bus outputs hold unless a bus cycle completes.
    always_comb begin
        state_d     = state;
        cmd_d       = cmd_q;
        width_d     = width_q;
        tag_d       = tag_q;
        data_hi_d   = data_hi_q;
        lo_d        = lo_q;
        data_out_d  = data_out;
        data_tag_d  = data_tag;
        data_wb_d   = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_rd_d    = mem_rd;
        mem_wr_d    = mem_wr;

        case (state)
            IDLE: begin
                if (rq_start) begin
                    cmd_d       = rq_cmd;
                    width_d     = rq_width;
                    tag_d       = rq_tag;
                    data_hi_d   = rq_data[15:8];
                    mem_addr_d  = rq_addr;
                    mem_wdata_d = rq_data[7:0];
                    mem_rd_d    = (rq_cmd == CMD_LOAD);
                    mem_wr_d    = (rq_cmd == CMD_STORE);
                    state_d     = LO;
                end
            end
            LO: begin
                if (bus_done) begin
                    if (width_q == WIDTH_16) begin
                        // Second byte goes to the next address, wrapping at the top of the space.
                        lo_d        = mem_rdata;
                        mem_addr_d  = mem_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                        mem_wdata_d = data_hi_q;
                        state_d     = HI;
                    end else begin
                        mem_rd_d = 1'b0;
                        mem_wr_d = 1'b0;
                        state_d  = IDLE;
                        if (cmd_q == CMD_LOAD) begin
                            data_wb_d  = 1'b1;
                            data_out_d = {8'h00, mem_rdata};
                            data_tag_d = tag_q;
                        end
                    end
                end
            end
            HI: begin
                if (bus_done) begin
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    state_d  = IDLE;
                    if (cmd_q == CMD_LOAD) begin
                        data_wb_d  = 1'b1;
                        data_out_d = {mem_rdata, lo_q};
                        data_tag_d = tag_q;
                    end
                end
            end
            default: begin
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

endmodule : load_store_unit
